// File: rtl/whiten_sequencer_if.sv
// Handshake bundle between the whitening run controller and its datapath.
// master = sequencer side, slave = datapath/environment side.
interface whiten_sequencer_if #(
  parameter int SIZE_A = 8
);
  localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;

  logic                    start;
  logic signed [31:0]      scale;
  logic                    conv_en;
  logic                    eig_start;
  logic signed [31:0]      eig_scale;
  logic                    eig_done;
  logic                    proj_valid;
  logic        [ROW_W-1:0] proj_row;
  logic                    proj_ready;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic        [2:0]       state_o;

  modport master (
    input  start, scale, eig_done, proj_ready,
    output conv_en, eig_start, eig_scale, proj_valid, proj_row,
           busy, done, err, state_o
  );

  modport slave (
    output start, scale, eig_done, proj_ready,
    input  conv_en, eig_start, eig_scale, proj_valid, proj_row,
           busy, done, err, state_o
  );
endinterface

// File: rtl/whiten_sequencer.sv
// Run-level controller for the whitening datapath: conversion, eigen solve
// with watchdog, then row-by-row projection issue.
module whiten_sequencer #(
  parameter int SIZE_A      = 8,
  parameter int CONV_LAT    = 4,
  parameter int EIG_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  whiten_sequencer_if.master  bus
);
  localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_LAT - 1);
  localparam logic [CNT_W-1:0] EIG_LAST  = CNT_W'(EIG_TIMEOUT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(SIZE_A - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_EIGEN   = 3'd2,
    S_PROJECT = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [ROW_W-1:0]   row_q, row_d;
  logic signed [31:0]        scale_q, scale_d;
  logic                      eig_start_q, eig_start_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      scale_q     <= '0;
      eig_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      scale_q     <= scale_d;
      eig_start_q <= eig_start_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    scale_d     = scale_q;
    eig_start_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          scale_d = bus.scale;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // The launch pulse is registered here so it lines up with EIGEN entry.
        if (cnt_q == CONV_LAST) begin
          cnt_d       = '0;
          eig_start_d = 1'b1;
          state_d     = S_EIGEN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EIGEN: begin
        // Completion takes priority over the watchdog on the final cycle.
        if (bus.eig_done) begin
          row_d   = '0;
          state_d = S_PROJECT;
        end else if (cnt_q == EIG_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PROJECT: begin
        if (bus.proj_ready) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a pure decode of registered state, never of inputs.
  assign bus.conv_en    = (state_q == S_CONVERT);
  assign bus.eig_start  = eig_start_q;
  assign bus.eig_scale  = scale_q;
  assign bus.proj_valid = (state_q == S_PROJECT);
  assign bus.proj_row   = row_q;
  assign bus.busy       = (state_q == S_CONVERT) || (state_q == S_EIGEN) ||
                          (state_q == S_PROJECT);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERROR);
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_whiten_sequencer.sv
// Randomized bench for whiten_sequencer: a phase/elapsed-cycle model checked
// every cycle, plus literal expectations from the directed scenarios.
module tb_whiten_sequencer;
  localparam int SIZE_A      = 8;
  localparam int CONV_LAT    = 4;
  localparam int EIG_TIMEOUT = 20;
  localparam int CNT_W       = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  whiten_sequencer_if #(.SIZE_A(SIZE_A)) bus ();

  whiten_sequencer #(
    .SIZE_A(SIZE_A), .CONV_LAT(CONV_LAT), .EIG_TIMEOUT(EIG_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: current phase, cycles elapsed in it, row, latched scale.
  int                 m_phase = 0;
  int                 m_t     = 0;
  int                 m_row   = 0;
  logic signed [31:0] m_scale = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_t = 0; m_row = 0; m_scale = '0;
    end else begin
      case (m_phase)
        0, 4, 5: if (bus.start) begin
          m_scale = bus.scale; m_phase = 1; m_t = 0;
        end
        1: begin
          m_t++;
          if (m_t == CONV_LAT) begin m_phase = 2; m_t = 0; end
        end
        2: begin
          m_t++;
          if (bus.eig_done) begin m_phase = 3; m_row = 0; end
          else if (m_t == EIG_TIMEOUT) m_phase = 5;
        end
        3: if (bus.proj_ready) begin
          if (m_row == SIZE_A - 1) begin m_phase = 4; m_row = 0; end
          else m_row++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  int conv_cnt, eig_pulse, eig_cyc, proj_cyc, hs_cnt, err_cnt;

  always @(negedge clk) begin
    chk("state_o",    bus.state_o,    m_phase);
    chk("conv_en",    bus.conv_en,    m_phase == 1);
    chk("eig_start",  bus.eig_start,  (m_phase == 2) && (m_t == 0));
    chk("eig_scale",  bus.eig_scale,  m_scale);
    chk("proj_valid", bus.proj_valid, m_phase == 3);
    chk("proj_row",   bus.proj_row,   m_row);
    chk("busy",       bus.busy,       m_phase >= 1 && m_phase <= 3);
    chk("done",       bus.done,       m_phase == 4);
    chk("err",        bus.err,        m_phase == 5);
    if (bus.conv_en)   conv_cnt++;
    if (bus.eig_start) eig_pulse++;
    if (bus.state_o == 3'd2) eig_cyc++;
    if (bus.proj_valid) proj_cyc++;
    if (bus.err) err_cnt++;
    if (bus.proj_valid && bus.proj_ready) begin
      chk("hs_row", bus.proj_row, hs_cnt % SIZE_A);
      hs_cnt++;
    end
  end

  // mode: 0 ready always, 1 ready toggling, 2 ready random; done_delay<0 never.
  task automatic run(input logic signed [31:0] s, input int done_delay, input int mode,
                     input bit noise, input int stop_row);
    int eig_n = 0;
    int cyc   = 0;
    conv_cnt = 0; eig_pulse = 0; eig_cyc = 0; proj_cyc = 0; hs_cnt = 0; err_cnt = 0;
    bus.start = 1'b1; bus.scale = s; bus.eig_done = 1'b0; bus.proj_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.start    = 1'b0;
      bus.eig_done = 1'b0;
      if (m_phase == 4 || m_phase == 5) break;
      if (stop_row >= 0 && m_phase == 3 && m_row == stop_row) break;
      if (cyc > 500) begin
        n_chk++; n_fail++;
        $display("FAIL run_bound: got %0d cycles, expected completion", cyc);
        break;
      end
      if (m_phase == 2) begin
        if (eig_n == done_delay) bus.eig_done = 1'b1;
        eig_n++;
      end else if (noise) begin
        bus.eig_done = 1'($urandom % 2);
      end
      case (mode)
        0:       bus.proj_ready = 1'b1;
        1:       bus.proj_ready = cyc[0];
        default: bus.proj_ready = 1'($urandom % 2);
      endcase
      if (noise && ($urandom % 4 == 0) && m_phase >= 1 && m_phase <= 3) begin
        bus.start = 1'b1;
        bus.scale = $urandom;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.scale = '0; bus.eig_done = 1'b0; bus.proj_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", bus.state_o, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_scale", bus.eig_scale, 0);
    chk("rst_valid", bus.proj_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: scale 5, eig_done on the 11th EIGEN cycle, ready always.
    run(32'sd5, 10, 0, 1'b0, -1);
    @(negedge clk); #1;
    chk("d1_conv_cycles", conv_cnt, 4);
    chk("d1_eig_pulses", eig_pulse, 1);
    chk("d1_eig_cycles", eig_cyc, 11);
    chk("d1_eig_scale", bus.eig_scale, 5);
    chk("d1_handshakes", hs_cnt, 8);
    chk("d1_proj_cycles", proj_cyc, 8);
    chk("d1_done", bus.done, 1);
    chk("d1_busy", bus.busy, 0);
    @(posedge clk); #1;

    // Directed: ready toggling.
    run(32'sd9, 3, 1, 1'b0, -1);
    @(negedge clk); #1;
    chk("d2_handshakes", hs_cnt, 8);
    chk("d2_done", bus.done, 1);
    @(posedge clk); #1;

    // Directed: watchdog expiry, then restart with a negative scale.
    run(32'sd4660, -1, 0, 1'b0, -1);
    @(negedge clk); #1;
    chk("d3_eig_cycles", eig_cyc, 20);
    chk("d3_err", bus.err, 1);
    chk("d3_state", bus.state_o, 5);
    chk("d3_busy", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.scale = -32'sd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #1;
    chk("d3_restart_state", bus.state_o, 1);
    chk("d3_restart_err", bus.err, 0);
    chk("d3_restart_scale", bus.eig_scale, -3);
    run(32'sd77, 2, 0, 1'b0, -1);
    @(negedge clk); #1;
    chk("d3_busy_start_scale", bus.eig_scale, -3);
    @(posedge clk); #1;

    // Directed: eig_done on the exact watchdog cycle.
    run(32'sd12, 19, 0, 1'b0, -1);
    @(negedge clk); #1;
    chk("d4_eig_cycles", eig_cyc, 20);
    chk("d4_err_seen", err_cnt, 0);
    chk("d4_done", bus.done, 1);
    @(posedge clk); #1;

    // Randomized runs with noisy inputs.
    for (int r = 0; r < 25; r++) begin
      int dly;
      dly = ($urandom % 5 == 0) ? -1 : int'($urandom_range(0, 22));
      run($urandom, dly, 2, 1'b1, -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Directed: busy-time start ignored, then async reset at row 3.
    run(32'sd7, 2, 0, 1'b0, 3);
    bus.start = 1'b1; bus.scale = 32'sd99; bus.proj_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #1;
    chk("d5_state", bus.state_o, 3);
    chk("d5_row", bus.proj_row, 3);
    chk("d5_scale", bus.eig_scale, 7);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("d5_rst_state", bus.state_o, 0);
    chk("d5_rst_valid", bus.proj_valid, 0);
    chk("d5_rst_row", bus.proj_row, 0);
    chk("d5_rst_scale", bus.eig_scale, 0);
    chk("d5_rst_flags", {bus.busy, bus.done, bus.err, bus.conv_en, bus.eig_start}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(32'sd11, 0, 0, 1'b0, -1);
    @(negedge clk); #1;
    chk("d6_done", bus.done, 1);
    chk("d6_scale", bus.eig_scale, 11);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
